// File: rtl/balanca_pkg.sv
// Shared scale definitions: datapath widths, weight saturation value and the
// controller state encoding used by the multiplier, divider and display paths.
package balanca_pkg;

    localparam int W_PESO  = 12;
    localparam int W_CENT  = 10;
    localparam int W_PRECO = 29;

    localparam logic [W_PESO-1:0] PESO_SAT = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } estado_t;

endpackage

// File: rtl/divisor_preco_div_passo.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_passo
    import balanca_pkg::*;
(
    input  logic [W_CENT:0]   r_i,
    input  logic              bit_i,
    input  logic [W_CENT-1:0] centimos_i,
    output logic [W_CENT:0]   r_o,
    output logic              q_o
);

    logic [W_CENT+1:0] t;
    logic [W_CENT+1:0] divisor;

    assign t       = {r_i, bit_i};
    assign divisor = (W_CENT+2)'(centimos_i);
    assign q_o     = (t >= divisor);
    // The new remainder is always below the divisor, so dropping the top bit is lossless.
    assign r_o     = q_o ? (W_CENT+1)'(t - divisor) : (W_CENT+1)'(t);

endmodule

// File: rtl/divisor_preco.sv
// Sequential restoring divider: weightInGrams = preco / centimos with remainder,
// one quotient bit per cycle, with overflow and divide-by-zero detection.
module divisor_preco
    import balanca_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W_PRECO-1:0] preco,
    input  logic [W_CENT-1:0]  centimos,
    output logic               busy,
    output logic               done,
    output logic [W_PESO-1:0]  weightInGrams,
    output logic [W_CENT-1:0]  resto,
    output logic               overflow,
    output logic               divZero
);

    localparam int HI_W  = W_PRECO - W_PESO;
    localparam int CNT_W = $clog2(W_PESO);

    estado_t             state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W_PESO-1:0]   lo_q, lo_d;
    logic [W_CENT-1:0]   cent_q, cent_d;
    logic [W_CENT:0]     r_q, r_d;
    logic [W_PESO-2:0]   quo_q, quo_d;
    logic [W_PESO-1:0]   weight_q, weight_d;
    logic [W_CENT-1:0]   resto_q, resto_d;
    logic                ovf_q, ovf_d;
    logic                dz_q, dz_d;

    logic [HI_W-1:0]     preco_hi;
    logic [W_CENT:0]     step_r;
    logic                step_q;

    assign preco_hi = preco[W_PRECO-1:W_PESO];

    div_passo u_passo (
        .r_i        (r_q),
        .bit_i      (lo_q[cnt_q]),
        .centimos_i (cent_q),
        .r_o        (step_r),
        .q_o        (step_q)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        cent_d   = cent_q;
        r_d      = r_q;
        quo_d    = quo_q;
        weight_d = weight_q;
        resto_d  = resto_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = preco[W_PESO-1:0];
                    cent_d   = centimos;
                    quo_d    = '0;
                    weight_d = '0;
                    resto_d  = '0;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    if (centimos == '0) begin
                        dz_d     = 1'b1;
                        weight_d = PESO_SAT;
                        state_d  = DONE;
                    end else if (preco_hi >= HI_W'(centimos)) begin
                        // Upper dividend already holds the divisor: quotient needs more than W_PESO bits.
                        ovf_d    = 1'b1;
                        weight_d = PESO_SAT;
                        state_d  = DONE;
                    end else begin
                        r_d     = preco_hi[W_CENT:0];
                        cnt_d   = CNT_W'(W_PESO - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                quo_d = {quo_q[W_PESO-3:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    weight_d = {quo_q, step_q};
                    resto_d  = step_r[W_CENT-1:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lo_q     <= '0;
            cent_q   <= '0;
            r_q      <= '0;
            quo_q    <= '0;
            weight_q <= '0;
            resto_q  <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            cent_q   <= cent_d;
            r_q      <= r_d;
            quo_q    <= quo_d;
            weight_q <= weight_d;
            resto_q  <= resto_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign weightInGrams = weight_q;
    assign resto         = resto_q;
    assign overflow      = ovf_q;
    assign divZero       = dz_q;

endmodule

// File: tb/tb_divisor_preco.sv
// Self-checking bench for divisor_preco: arithmetic reference model compared
// every cycle, directed boundary cases and a randomized invariant sweep.
module tb_divisor_preco;
    import balanca_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic [W_PRECO-1:0] preco;
    logic [W_CENT-1:0]  centimos;
    logic               busy;
    logic               done;
    logic [W_PESO-1:0]  weightInGrams;
    logic [W_CENT-1:0]  resto;
    logic               overflow;
    logic               divZero;

    int n_chk = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    divisor_preco dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .preco         (preco),
        .centimos      (centimos),
        .busy          (busy),
        .done          (done),
        .weightInGrams (weightInGrams),
        .resto         (resto),
        .overflow      (overflow),
        .divZero       (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division plus the error rules and fixed latencies.
    typedef struct {
        logic [W_PESO-1:0] w;
        logic [W_CENT-1:0] r;
        logic              ovf;
        logic              dz;
        int                lat;
    } res_t;

    function automatic res_t model(input longint unsigned p, input longint unsigned c);
        res_t m;
        m.ovf = 1'b0;
        m.dz  = 1'b0;
        if (c == 0) begin
            m.dz = 1'b1; m.w = PESO_SAT; m.r = '0; m.lat = 1;
        end else if (p / c > 4095) begin
            m.ovf = 1'b1; m.w = PESO_SAT; m.r = '0; m.lat = 1;
        end else begin
            m.w = 12'(p / c); m.r = 10'(p % c); m.lat = 13;
        end
        return m;
    endfunction

    res_t cur;
    always_comb cur = model(64'(preco), 64'(centimos));

    // Model state: cycles left until the result window closes (0 = idle).
    int                left = 0;
    logic [W_PESO-1:0] m_w = '0, p_w = '0;
    logic [W_CENT-1:0] m_r = '0, p_r = '0;
    logic              m_ovf = 1'b0, m_dz = 1'b0, p_ovf = 1'b0, p_dz = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            left  <= 0;
            m_w   <= '0;
            m_r   <= '0;
            m_ovf <= 1'b0;
            m_dz  <= 1'b0;
        end else if (left == 0 && start) begin
            left <= cur.lat;
            if (cur.lat == 1) begin
                m_w <= cur.w; m_r <= cur.r; m_ovf <= cur.ovf; m_dz <= cur.dz;
            end else begin
                m_w <= '0; m_r <= '0; m_ovf <= 1'b0; m_dz <= 1'b0;
                p_w <= cur.w; p_r <= cur.r; p_ovf <= cur.ovf; p_dz <= cur.dz;
            end
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 2) begin
                m_w <= p_w; m_r <= p_r; m_ovf <= p_ovf; m_dz <= p_dz;
            end
        end
    end

    // Per-cycle compare; fields packed as busy,done,overflow,divZero,weight,resto.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_outputs",
                  64'({busy, done, overflow, divZero, weightInGrams, resto}),
                  64'({(left > 0), (left == 1), m_ovf, m_dz, m_w, m_r}));
        end
    end

    task automatic do_op(input logic [W_PRECO-1:0] p, input logic [W_CENT-1:0] c,
                         input int glitch, output int lat);
        @(negedge clk);
        preco    = p;
        centimos = c;
        start    = 1'b1;
        lat      = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (done) begin
                start = 1'b0;
                break;
            end
            if (lat >= 40) begin
                check("done_timeout", 64'(done), 64'd1);
                start = 1'b0;
                break;
            end
            start    = (glitch != 0 && lat == glitch);
            preco    = W_PRECO'($urandom);
            centimos = W_CENT'($urandom);
        end
    endtask

    int lat;
    int pulses;
    logic [W_PRECO-1:0] rp;
    logic [W_CENT-1:0]  rc;
    int rw, rr, gl;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        preco    = '0;
        centimos = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_state", 64'({busy, done, overflow, divZero, weightInGrams, resto}), 64'd0);
        reset = 1'b0;

        do_op(29'd705000, 10'd470, 0, lat);
        check("t1_latency", 64'(lat), 64'd13);
        check("t1_weight", 64'(weightInGrams), 64'd1500);
        check("t1_resto", 64'(resto), 64'd0);
        check("t1_flags", 64'({overflow, divZero}), 64'd0);

        do_op(29'd705469, 10'd470, 0, lat);
        check("t2_weight", 64'(weightInGrams), 64'd1500);
        check("t2_resto", 64'(resto), 64'd469);

        do_op(29'd4190207, 10'd1023, 0, lat);
        check("max_weight", 64'(weightInGrams), 64'd4095);
        check("max_resto", 64'(resto), 64'd1022);

        do_op(29'd1925119, 10'd470, 0, lat);
        check("edge_in_weight", 64'(weightInGrams), 64'd4095);
        check("edge_in_resto", 64'(resto), 64'd469);

        do_op(29'd1925120, 10'd470, 0, lat);
        check("edge_ovf_latency", 64'(lat), 64'd1);
        check("edge_ovf_flag", 64'(overflow), 64'd1);

        do_op(29'd4096, 10'd1, 0, lat);
        check("ovf_latency", 64'(lat), 64'd1);
        check("ovf_flags", 64'({overflow, divZero}), 64'b10);
        check("ovf_weight", 64'(weightInGrams), 64'hFFF);
        check("ovf_resto", 64'(resto), 64'd0);

        do_op(29'd100, 10'd0, 0, lat);
        check("dz_latency", 64'(lat), 64'd1);
        check("dz_flags", 64'({overflow, divZero}), 64'b01);
        check("dz_weight", 64'(weightInGrams), 64'hFFF);

        do_op(29'h1FFF_FFFF, 10'd0, 0, lat);
        check("dz_priority", 64'({overflow, divZero}), 64'b01);

        do_op(29'd0, 10'd5, 0, lat);
        check("zero_dividend", 64'({weightInGrams, resto}), 64'd0);

        do_op(29'd705000, 10'd470, 5, lat);
        check("glitch_latency", 64'(lat), 64'd13);
        check("glitch_weight", 64'(weightInGrams), 64'd1500);

        // Reset in IDLE with a result held, together with a start: reset wins.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset_start_clears", 64'({busy, done, overflow, divZero, weightInGrams, resto}), 64'd0);

        // Reset during the sixth CALC cycle discards the operation.
        @(negedge clk);
        preco    = 29'd705469;
        centimos = 10'd470;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_calc", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_calc", 64'({busy, done, overflow, divZero, weightInGrams, resto}), 64'd0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            pulses += int'(done);
        end
        check("no_done_after_reset", 64'(pulses), 64'd0);

        do_op(29'd705469, 10'd470, 0, lat);
        check("after_reset_weight", 64'(weightInGrams), 64'd1500);
        check("after_reset_resto", 64'(resto), 64'd469);

        for (int i = 0; i < 1000; i++) begin
            rw = int'($urandom_range(0, 4095));
            rc = W_CENT'($urandom_range(1, 1023));
            rr = int'($urandom_range(0, int'(rc) - 1));
            rp = W_PRECO'(rw * int'(rc) + rr);
            gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 11)) : 0;
            do_op(rp, rc, gl, lat);
            check("rand_latency", 64'(lat), 64'd13);
            check("rand_weight", 64'(weightInGrams), 64'(rw));
            check("rand_resto", 64'(resto), 64'(rr));
        end

        for (int i = 0; i < 40; i++) begin
            rc = ($urandom_range(0, 3) == 0) ? W_CENT'(0) : W_CENT'($urandom_range(1, 1023));
            rp = W_PRECO'($urandom);
            do_op(rp, rc, 0, lat);
            check("rand_err_latency", 64'(lat),
                  64'((rc == 0 || 64'(rp) >= 64'(rc) * 4096) ? 1 : 13));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
